// File: rtl/adder_result_stage.sv
// Registered result stage behind the CLA adder.
// Two-entry skid buffer with N/Z/C/V flag derivation and status commit.
module adder_result_stage #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] S,
  input  logic             Cout,
  input  logic             AMsb,
  input  logic             BMsb,
  input  logic             Sub,
  input  logic [3:0]       FlagWe,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ResFlags,
  output logic [3:0]       Flags,
  input  logic             FlagClr
);

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [3:0]       f;
    logic [3:0]       we;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t     state, state_n;
  entry_t     main_q, main_n;
  entry_t     skid_q, skid_n;
  entry_t     in_e;
  logic       in_ready_q;
  logic [3:0] flags_q, flags_n;
  logic [3:0] base;
  logic       in_x, out_x;

  always_comb begin
    in_e.s    = S;
    in_e.f[3] = S[WIDTH-1];
    in_e.f[2] = (S == '0);
    in_e.f[1] = Cout ^ Sub;
    in_e.f[0] = (AMsb ~^ BMsb) & (S[WIDTH-1] ^ AMsb);
    in_e.we   = FlagWe;
  end

  assign in_x = InValid & in_ready_q;
  assign out_x = (state != EMPTY) & OutReady;

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    unique case (state)
      EMPTY: begin
        if (in_x) begin
          main_n  = in_e;
          state_n = ONE;
        end
      end
      ONE: begin
        unique case ({in_x, out_x})
          2'b10: begin
            skid_n  = in_e;
            state_n = TWO;
          end
          2'b01: state_n = EMPTY;
          2'b11: main_n = in_e;
          default: ;
        endcase
      end
      TWO: begin
        if (out_x) begin
          main_n  = skid_q;
          state_n = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // Clear applies before the commit, so enabled bits win.
  always_comb begin
    base    = FlagClr ? 4'b0000 : flags_q;
    flags_n = base;
    if (out_x)
      flags_n = (base & ~main_q.we) | (main_q.f & main_q.we);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      flags_q    <= 4'b0000;
    end else begin
      state      <= state_n;
      main_q     <= main_n;
      skid_q     <= skid_n;
      in_ready_q <= (state_n != TWO);
      flags_q    <= flags_n;
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = (state != EMPTY);
  assign Result   = main_q.s;
  assign ResFlags = main_q.f;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Bench for adder_result_stage: directed cases plus random traffic.
// Reference model is a FIFO queue with flags from signed/unsigned arithmetic.
module tb_adder_result_stage;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [15:0] S = '0;
  logic        Cout = 1'b0;
  logic        AMsb = 1'b0;
  logic        BMsb = 1'b0;
  logic        Sub = 1'b0;
  logic [3:0]  FlagWe = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [15:0] Result;
  logic [3:0]  ResFlags;
  logic [3:0]  Flags;
  logic        FlagClr = 1'b0;

  adder_result_stage #(.WIDTH(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .InValid(InValid), .InReady(InReady),
    .S(S), .Cout(Cout), .AMsb(AMsb), .BMsb(BMsb),
    .Sub(Sub), .FlagWe(FlagWe),
    .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .ResFlags(ResFlags),
    .Flags(Flags), .FlagClr(FlagClr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] s;
    logic [3:0]  f;
    logic [3:0]  we;
  } ent_t;

  ent_t       q[$];
  ent_t       cur;
  logic [3:0] mflags = 4'b0000;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive the adder outputs for a op b and predict the flags.
  task automatic set_op(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic sub,
                        input logic [3:0] we);
    logic [15:0] bb;
    logic [16:0] r;
    int sa, sb, res;
    bb = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + {16'b0, sub};
    S = r[15:0];
    Cout = r[16];
    AMsb = a[15];
    BMsb = bb[15];
    Sub = sub;
    FlagWe = we;
    sa = $signed(a);
    sb = $signed(b);
    res = sub ? sa - sb : sa + sb;
    cur.s = r[15:0];
    cur.f[3] = r[15];
    cur.f[2] = (r[15:0] == 16'h0);
    cur.f[1] = sub ? (a < b) : r[16];
    cur.f[0] = (res > 32767) || (res < -32768);
    cur.we = we;
  endtask

  task automatic tick();
    bit ix, ox;
    logic [3:0] base;
    check("out_valid", OutValid, q.size() > 0);
    check("in_ready", InReady, q.size() < 2);
    check("flags", Flags, mflags);
    if (q.size() > 0) begin
      check("result", Result, q[0].s);
      check("res_flags", ResFlags, q[0].f);
    end
    ix = InValid && (q.size() < 2);
    ox = OutReady && (q.size() > 0);
    @(posedge Clk);
    if (ox) begin
      base = FlagClr ? 4'b0000 : mflags;
      mflags = (base & ~q[0].we) | (q[0].f & q[0].we);
      void'(q.pop_front());
    end else if (FlagClr) begin
      mflags = 4'b0000;
    end
    if (ix) q.push_back(cur);
    @(negedge Clk);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("rst_out_valid", OutValid, 0);
    check("rst_flags", Flags, 0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_in_ready", InReady, 1);
    check("rst_result", Result, 0);
    check("rst_res_flags", ResFlags, 0);

    // 0x7FFF + 1: signed overflow into negative
    set_op(16'h7FFF, 16'h0001, 1'b0, 4'hF);
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    check("t1_result", Result, 16'h8000);
    check("t1_res_flags", ResFlags, 4'b1001);
    OutReady = 1'b1;
    tick();
    check("t1_flags", Flags, 4'b1001);

    // 0xFFFF + 1 writes only C
    set_op(16'hFFFF, 16'h0001, 1'b0, 4'b0100 >> 1);
    InValid = 1'b1;
    OutReady = 1'b0;
    tick();
    InValid = 1'b0;
    check("t2_res_flags", ResFlags, 4'b0110);
    OutReady = 1'b1;
    tick();
    check("t2_flags", Flags, 4'b1011);

    // 5 - 7 borrows
    set_op(16'd5, 16'd7, 1'b1, 4'hF);
    InValid = 1'b1;
    OutReady = 1'b0;
    tick();
    InValid = 1'b0;
    check("t3_res_flags", ResFlags, 4'b1010);
    OutReady = 1'b1;
    tick();

    // Backpressure: 1,2 accepted, 3 held off
    OutReady = 1'b0;
    InValid = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      set_op(16'(v), 16'h0, 1'b0, 4'h0);
      if (v == 3) check("t4_held_off", InReady, 0);
      tick();
    end
    OutReady = 1'b1;
    tick();
    tick();
    InValid = 1'b0;
    check("t4_third", Result, 16'd3);
    tick();
    tick();

    // Streaming at full rate
    InValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
      check("t5_in_ready", InReady, 1);
      tick();
    end
    InValid = 1'b0;
    tick();
    tick();

    // Set Flags to 1100, then clear coincident with a commit
    OutReady = 1'b1;
    FlagClr = 1'b1;
    tick();
    FlagClr = 1'b0;
    InValid = 1'b1;
    set_op(16'h8000, 16'h0000, 1'b0, 4'b1000);
    tick();
    set_op(16'h0000, 16'h0000, 1'b0, 4'b0100);
    tick();
    set_op(16'h8000, 16'h8000, 1'b0, 4'b0011);
    tick();
    InValid = 1'b0;
    check("t6_before", Flags, 4'b1100);
    FlagClr = 1'b1;
    tick();
    FlagClr = 1'b0;
    check("t6_clr_commit", Flags, 4'b0011);

    // Reset while both entries are full
    OutReady = 1'b0;
    InValid = 1'b1;
    set_op(16'h1234, 16'h1111, 1'b0, 4'hF);
    tick();
    tick();
    InValid = 1'b0;
    check("t6_two", InReady, 0);
    Rst_n = 1'b0;
    #1;
    check("t6_rst_valid", OutValid, 0);
    check("t6_rst_flags", Flags, 0);
    q.delete();
    mflags = 4'b0000;
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      InValid = 1'($urandom);
      OutReady = ($urandom_range(0, 3) != 0);
      FlagClr = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: set_op(16'h0, 16'h0, 1'($urandom), 4'($urandom));
        1: set_op(16'($urandom), 16'($urandom), 1'b1, 4'($urandom));
        default: set_op(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
      endcase
      tick();
    end
    InValid = 1'b0;
    FlagClr = 1'b0;
    OutReady = 1'b1;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
